dtc_seq_walker: RTL and testbench

- Programmable, sequential decision-tree classifier. Reads a node table written by a host config port and walks it one level per cycle.
- Takes a 12-bit feature vector in, returns a 3-bit class out, with valid/ready handshakes on both sides.
- Sits beside the hardwired dtc_split05 classifiers. It gives the same class for the same tree, so trees can be changed at run time without re-synthesis.

---
 rtl/dtc_seq_walker.sv | 128 ++++++++++++
 tb/tb_dtc_seq_walker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_seq_walker.sv
// Programmable decision-tree classifier: walks a host-written node table one
// level per cycle and returns the leaf class, or an error on a runaway walk.
module dtc_seq_walker #(
  parameter int FEAT_W    = 12,
  parameter int CLS_W     = 3,
  parameter int NODE_AW   = 6,
  parameter int MAX_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [16:0]        cfg_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FEAT_W-1:0]  in_feat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic               out_err,
  output logic               busy
);

  localparam int                 NODES      = 1 << NODE_AW;
  localparam int                 DEPTH_W    = $clog2(MAX_DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);
  localparam logic [4:0]         FEAT_LIM   = 5'(FEAT_W);
  localparam logic [16:0]        LEAF_CLS0  = 17'h10000;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [16:0]         node_tbl_q [NODES];
  logic [FEAT_W-1:0]   feat_q, feat_d;
  logic [NODE_AW-1:0]  ptr_q, ptr_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [CLS_W-1:0]    cls_q, cls_d;
  logic                err_q, err_d;

  logic [16:0]         entry;
  logic [3:0]          fidx;
  logic [15:0]         feat_ext;
  logic                bad_idx;
  logic                fbit;

  assign entry    = node_tbl_q[ptr_q];
  assign fidx     = entry[15:12];
  assign feat_ext = 16'(feat_q);
  assign bad_idx  = {1'b0, fidx} >= FEAT_LIM;
  assign fbit     = feat_ext[fidx];

  // NOTE: the table is a register array, so it can (and must) be reset; every
  // entry returns to "leaf, class 0" so a fresh walker never reads garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) node_tbl_q[i] <= LEAF_CLS0;
    end else if (cfg_we && state_q == S_IDLE) begin
      node_tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      feat_q  <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      cls_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every next-state signal gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    cls_d   = cls_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          feat_d  = in_feat;
          ptr_d   = '0;
          depth_d = '0;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (entry[16]) begin
          cls_d   = entry[CLS_W-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (bad_idx || depth_q == DEPTH_LAST) begin
          // Bad feature index or too many internal nodes (also catches loops).
          cls_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ptr_d   = fbit ? entry[11:6] : entry[5:0];
          depth_d = depth_q + DEPTH_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_class = cls_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dtc_seq_walker.sv
// Scoreboard bench for dtc_seq_walker: directed tree scenarios plus random
// tables and vectors, checked against a behavioural tree-walk model.
module tb_dtc_seq_walker;

  localparam int FEAT_W    = 12;
  localparam int CLS_W     = 3;
  localparam int NODE_AW   = 6;
  localparam int MAX_DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [NODE_AW-1:0] cfg_addr = '0;
  logic [16:0]        cfg_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [FEAT_W-1:0]  in_feat = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CLS_W-1:0]   out_class;
  logic               out_err;
  logic               busy;

  dtc_seq_walker #(
    .FEAT_W(FEAT_W), .CLS_W(CLS_W), .NODE_AW(NODE_AW), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CLS_W-1:0] cls;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [16:0] mtbl [1 << NODE_AW];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << NODE_AW); i++) mtbl[i] = 17'h10000;
  endtask

  // Reference walk: follow the table from node 0, counting visited nodes.
  function automatic void model(input logic [FEAT_W-1:0] f, output logic [CLS_W-1:0] c,
                                output logic e, output int n);
    int          ptr;
    int          fi;
    logic [16:0] ent;
    ptr = 0;
    c   = '0;
    e   = 1'b1;
    n   = MAX_DEPTH;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      ent = mtbl[ptr];
      fi  = int'(ent[15:12]);
      n   = k;
      if (ent[16]) begin
        c = ent[CLS_W-1:0];
        e = 1'b0;
        return;
      end
      if (fi >= FEAT_W || k == MAX_DEPTH) begin
        c = '0;
        e = 1'b1;
        return;
      end
      ptr = f[fi] ? int'(ent[11:6]) : int'(ent[5:0]);
    end
  endfunction

  // All driving tasks are entered just after a rising edge.
  task automatic cfg_write(input logic [NODE_AW-1:0] a, input logic [16:0] d, input bit taken);
    cfg_addr = a;
    cfg_data = d;
    cfg_we   = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (taken) mtbl[a] = d;
  endtask

  task automatic send(input logic [FEAT_W-1:0] f, input bit do_cfg,
                      input logic [NODE_AW-1:0] a, input logic [16:0] d);
    bit               got;
    logic [CLS_W-1:0] c;
    logic             e;
    int               n;
    got      = 1'b0;
    in_feat  = f;
    in_valid = 1'b1;
    if (do_cfg) begin
      cfg_addr = a;
      cfg_data = d;
      cfg_we   = 1'b1;
      mtbl[a]  = d;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        model(f, c, e, n);
        sb_q.push_back('{cls: c, err: e, cyc: cyc + n + 1});
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    if (i == 400) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] rand_entry();
    logic [16:0] e;
    e = 17'($urandom);
    if ($urandom_range(0, 9) < 4) begin
      e[16] = 1'b1;
    end else begin
      e[16]    = 1'b0;
      e[15:12] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                            : 4'($urandom_range(0, 11));
      e[11:6]  = 6'($urandom_range(0, 19));
      e[5:0]   = 6'($urandom_range(0, 19));
    end
    return e;
  endfunction

  // Monitor: hold stability while stalled, and scoreboard compare on handshake.
  initial begin
    bit               held;
    int               rise;
    logic [CLS_W-1:0] hcls;
    logic             herr;
    exp_t             ex;
    held = 1'b0;
    rise = 0;
    hcls = '0;
    herr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) check("valid_held", 32'(out_valid), 32'd1);
        if (out_valid) begin
          if (!held) begin
            rise = cyc;
            hcls = out_class;
            herr = out_err;
          end else begin
            check("class_stable", 32'(out_class), 32'(hcls));
            check("err_stable", 32'(out_err), 32'(herr));
          end
          check("in_ready_done", 32'(in_ready), 32'd0);
          check("busy_done", 32'(busy), 32'd1);
          if (out_ready) begin
            if (sb_q.size() == 0) begin
              check("unexpected_out", 32'd1, 32'd0);
            end else begin
              ex = sb_q.pop_front();
              check("class", 32'(out_class), 32'(ex.cls));
              check("err", 32'(out_err), 32'(ex.err));
              check("latency", rise, ex.cyc);
            end
          end
          held = !out_ready;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Empty table: single leaf, busy for WALK + DONE.
    send(12'h000, 1'b0, '0, '0);
    @(negedge clk);
    check("busy_walk", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_done_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Three-node tree on feature bit 6.
    cfg_write(6'd0, {1'b0, 4'd6, 6'd1, 6'd2}, 1'b1);
    cfg_write(6'd1, {1'b1, 13'd0, 3'b111}, 1'b1);
    cfg_write(6'd2, {1'b1, 13'd0, 3'b001}, 1'b1);
    send(12'h040, 1'b0, '0, '0);
    send(12'h000, 1'b0, '0, '0);

    // Backpressure in DONE with an ignored table write.
    wait_idle();
    out_ready = 1'b0;
    send(12'h040, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    cfg_write(6'd1, {1'b1, 13'd0, 3'b010}, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_class", 32'(out_class), 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    send(12'h040, 1'b0, '0, '0);

    // Table write and input handshake in the same IDLE cycle.
    wait_idle();
    send(12'h000, 1'b1, 6'd2, {1'b1, 13'd0, 3'b100});

    // Bad feature index at the root.
    wait_idle();
    cfg_write(6'd0, {1'b0, 4'd13, 6'd1, 6'd2}, 1'b1);
    send(12'hfff, 1'b0, '0, '0);

    // Self-loop at the root hits the depth cap.
    wait_idle();
    cfg_write(6'd0, 17'h00000, 1'b1);
    send(12'h123, 1'b0, '0, '0);

    // Reset one cycle after acceptance: result dropped, table cleared.
    wait_idle();
    send(12'h5a5, 1'b0, '0, '0);
    rst_n = 1'b0;
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    send(12'h5a5, 1'b0, '0, '0);

    // Random tables, vectors, gaps and consumer stalls.
    wait_idle();
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_idle();
      for (int a = 0; a < 16; a++) cfg_write(6'(a), rand_entry(), 1'b1);
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(12'($urandom), 1'b0, '0, '0);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
